// File: rtl/weight_loader.sv
// rtl/weight_loader.sv - streams kernel weights into ROM_NUM banks, kernel k to bank k mod ROM_NUM
module weight_loader #(
    parameter int DW          = 8,
    parameter int ROM_NUM     = 4,
    parameter int ABS_ADDR_DW = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [15:0]            KERNEL_NUM,
    input  logic [15:0]            kernel_elem,
    input  logic [DW-1:0]          in_data,
    input  logic                   in_valid,
    output logic                   in_ready,
    output logic [ROM_NUM-1:0]     wr_en,
    output logic [ABS_ADDR_DW-1:0] wr_addr,
    output logic [DW-1:0]          wr_data,
    output logic                   busy,
    output logic                   done
);
    localparam int BW = (ROM_NUM > 1) ? $clog2(ROM_NUM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                 state;
    logic [15:0]            kern_num_q;
    logic [15:0]            elem_num_q;
    logic [15:0]            elem_cnt;
    logic [15:0]            kern_cnt;
    logic [BW-1:0]          bank_cnt;
    logic [ABS_ADDR_DW-1:0] base_addr;
    logic                   accept;
    logic                   last_elem;
    logic                   last_kern;
    logic                   last_bank;

    assign in_ready  = (state == LOAD);
    assign busy      = (state == LOAD) || (state == DONE);
    assign done      = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign last_elem = (elem_cnt == elem_num_q - 16'd1);
    assign last_kern = (kern_cnt == kern_num_q - 16'd1);
    assign last_bank = (bank_cnt == BW'(ROM_NUM - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            kern_num_q <= '0;
            elem_num_q <= '0;
            elem_cnt   <= '0;
            kern_cnt   <= '0;
            bank_cnt   <= '0;
            base_addr  <= '0;
            wr_en      <= '0;
            wr_addr    <= '0;
            wr_data    <= '0;
        end else begin
            wr_en <= '0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (KERNEL_NUM == 16'd0 || kernel_elem == 16'd0) begin
                            state <= DONE;
                        end else begin
                            kern_num_q <= KERNEL_NUM;
                            elem_num_q <= kernel_elem;
                            elem_cnt   <= '0;
                            kern_cnt   <= '0;
                            bank_cnt   <= '0;
                            base_addr  <= '0;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: begin
                    if (accept) begin
                        wr_en   <= ROM_NUM'(1) << bank_cnt;
                        wr_addr <= base_addr + ABS_ADDR_DW'(elem_cnt);
                        wr_data <= in_data;
                        if (last_elem) begin
                            // Kernel finished: move to next bank; a full bank row advances the base.
                            elem_cnt <= '0;
                            kern_cnt <= kern_cnt + 16'd1;
                            if (last_bank) begin
                                bank_cnt  <= '0;
                                base_addr <= base_addr + ABS_ADDR_DW'(elem_num_q);
                            end else begin
                                bank_cnt <= bank_cnt + BW'(1);
                            end
                            if (last_kern) state <= DONE;
                        end else begin
                            elem_cnt <= elem_cnt + 16'd1;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_weight_loader.sv
// tb/tb_weight_loader.sv - table-driven scoreboard bench for weight_loader
module tb_weight_loader;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [15:0] KERNEL_NUM = '0;
    logic [15:0] kernel_elem = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  wr_en;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        busy;
    logic        done;

    weight_loader #(.DW(8), .ROM_NUM(4), .ABS_ADDR_DW(16)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .KERNEL_NUM(KERNEL_NUM),
        .kernel_elem(kernel_elem), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int n_writes = 0;
    int n_done = 0;
    int done_cyc = -1;
    int last_wr_cyc = -1;
    logic busy_at_done = 1'b0;
    logic [27:0] exp_q[$];

    typedef struct {
        int knum;
        int kelem;
        int mode;       // 0 continuous, 1 toggling, 2 random, 3 start re-pulsed mid-load
        bit poke_done;  // pulse start during the DONE cycle
    } vec_t;

    vec_t tbl[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [27:0] model(input int w, input int kelem);
        int k;
        int e;
        logic [3:0]  en;
        logic [15:0] a;
        k  = w / kelem;
        e  = w % kelem;
        en = 4'b0001 << (k % 4);
        a  = 16'((k / 4) * kelem + e);
        return {en, a, 8'(w)};
    endfunction

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (rst_n) begin
            if (wr_en != 4'b0000) begin
                n_writes++;
                last_wr_cyc = cyc;
                if (exp_q.size() == 0) begin
                    check("unexpected_write", {36'd0, wr_en, wr_addr, wr_data}, 64'd0);
                end else begin
                    check("write", {36'd0, wr_en, wr_addr, wr_data}, {36'd0, exp_q.pop_front()});
                end
            end
            if (done) begin
                n_done++;
                done_cyc = cyc;
                busy_at_done = busy;
            end
        end
    end

    task automatic run_load(input vec_t v, input int idx);
        int total;
        int word;
        int guard;
        int start_cyc;
        logic valid;
        total = v.knum * v.kelem;
        n_writes = 0;
        n_done = 0;
        done_cyc = -1;
        last_wr_cyc = -1;
        exp_q.delete();

        @(posedge clk); #1;
        check($sformatf("idle_ready_%0d", idx), {63'd0, in_ready}, 64'd0);
        KERNEL_NUM  = 16'(v.knum);
        kernel_elem = 16'(v.kelem);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        KERNEL_NUM  = 16'hffff;
        kernel_elem = 16'h0007;
        if (total == 0)
            check($sformatf("zero_ready_%0d", idx), {63'd0, in_ready}, 64'd0);

        word = 0;
        guard = 0;
        while (word < total && guard < 2000) begin
            check($sformatf("load_busy_ready_%0d", idx), {62'd0, busy, in_ready}, 64'd3);
            case (v.mode)
                1:       valid = (guard % 2 == 0);
                2:       valid = 1'($urandom_range(0, 1));
                default: valid = 1'b1;
            endcase
            if (v.mode == 3 && guard == 5) begin
                start = 1'b1;
                KERNEL_NUM  = 16'd1;
                kernel_elem = 16'd1;
            end
            in_valid = valid;
            in_data  = 8'(word);
            if (valid) begin
                exp_q.push_back(model(word, v.kelem));
                word++;
            end
            @(posedge clk); #1;
            start = 1'b0;
            guard++;
        end
        in_valid = 1'b0;
        if (word < total)
            check($sformatf("timeout_%0d", idx), 64'(word), 64'(total));

        if (v.poke_done) begin
            KERNEL_NUM  = 16'd1;
            kernel_elem = 16'd1;
            start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            in_valid = 1'b1;
            check($sformatf("start_in_done_ready_%0d", idx), {63'd0, in_ready}, 64'd0);
            @(posedge clk); #1;
            check($sformatf("start_in_done_ready2_%0d", idx), {63'd0, in_ready}, 64'd0);
            in_valid = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check($sformatf("writes_%0d", idx), 64'(n_writes), 64'(total));
        check($sformatf("queue_empty_%0d", idx), 64'(exp_q.size()), 64'd0);
        check($sformatf("done_count_%0d", idx), 64'(n_done), 64'd1);
        check($sformatf("busy_at_done_%0d", idx), {63'd0, busy_at_done}, 64'd1);
        if (total == 0)
            check($sformatf("done_latency_%0d", idx), 64'(done_cyc), 64'(start_cyc));
        else
            check($sformatf("done_with_last_write_%0d", idx), 64'(done_cyc), 64'(last_wr_cyc));
    endtask

    initial begin
        tbl[0] = '{knum: 6, kelem: 25, mode: 0, poke_done: 1'b0};
        tbl[1] = '{knum: 3, kelem: 2,  mode: 1, poke_done: 1'b0};
        tbl[2] = '{knum: 0, kelem: 5,  mode: 0, poke_done: 1'b0};
        tbl[3] = '{knum: 3, kelem: 0,  mode: 0, poke_done: 1'b0};
        tbl[4] = '{knum: 5, kelem: 3,  mode: 2, poke_done: 1'b0};
        tbl[5] = '{knum: 4, kelem: 4,  mode: 3, poke_done: 1'b0};
        tbl[6] = '{knum: 1, kelem: 2,  mode: 0, poke_done: 1'b1};
        tbl[7] = '{knum: 9, kelem: 1,  mode: 0, poke_done: 1'b0};

        #3;
        check("reset_outputs", {35'd0, wr_en, wr_addr, wr_data, busy, done, in_ready},
              {35'd0, 4'd0, 16'd0, 8'd0, 3'd0});
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) run_load(tbl[i], i);

        // Reset asserted mid-load with the 10th write on the bus.
        n_writes = 0;
        exp_q.delete();
        @(posedge clk); #1;
        KERNEL_NUM = 16'd4;
        kernel_elem = 16'd5;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int w = 0; w < 10; w++) begin
            in_valid = 1'b1;
            in_data = 8'(w);
            exp_q.push_back(model(w, 5));
            @(posedge clk); #1;
        end
        in_data = 8'd10;
        exp_q.push_back(model(10, 5));
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("rst_mid_outputs", {60'd0, wr_en}, 64'd0);
        check("rst_mid_state", {62'd0, busy, in_ready}, 64'd0);
        check("rst_mid_writes", 64'(n_writes), 64'd10);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        n_writes = 0;
        repeat (4) begin
            @(posedge clk); #1;
            check("post_rst_ready", {63'd0, in_ready}, 64'd0);
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("post_rst_writes", 64'(n_writes), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/weight_loader.md
WEIGHT_LOADER -- requirements
Module: weight_loader

Interface
REQ-001 Parameter DW, default 8: weight word width in bits.
REQ-002 Parameter ROM_NUM, default 4: number of weight banks, one per array column.
REQ-003 Parameter ABS_ADDR_DW, default 16: bank address width in bits.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst_n, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port start, input, 1 bit: single-cycle pulse that begins a load; sampled only in IDLE.
REQ-007 Port KERNEL_NUM, input, 16 bits: number of kernels to load; captured on start.
REQ-008 Port kernel_elem, input, 16 bits: elements per kernel; captured on start.
REQ-009 Port in_data, input, DW bits: incoming weight word.
REQ-010 Port in_valid, input, 1 bit: in_data is valid.
REQ-011 Port in_ready, output, 1 bit: the loader accepts a word this cycle.
REQ-012 Port wr_en, output, ROM_NUM bits: one-hot bank write strobe.
REQ-013 Port wr_addr, output, ABS_ADDR_DW bits: bank write address.
REQ-014 Port wr_data, output, DW bits: bank write data.
REQ-015 Port busy, output, 1 bit: high in LOAD and DONE.
REQ-016 Port done, output, 1 bit: single-cycle completion pulse.

Function
REQ-017 The FSM SHALL have states IDLE, LOAD and DONE and SHALL reset to IDLE.
REQ-018 On start in IDLE with nonzero KERNEL_NUM and kernel_elem, the FSM SHALL capture both values, clear all counters, and enter LOAD.
REQ-019 On start in IDLE with KERNEL_NUM==0 or kernel_elem==0, the FSM SHALL enter DONE directly and issue no writes.
REQ-020 in_ready SHALL equal (state==LOAD); a word is accepted when in_valid && in_ready.
REQ-021 Input stream order SHALL be kernel-major, element-minor: all elements of kernel 0, then all of kernel 1, and so on.
REQ-022 Element e of kernel k SHALL be written to bank (k mod ROM_NUM) at address (k div ROM_NUM)*kernel_elem + e, so that bank i at base_addr + e holds the weight a column reader fetches for kernel rom_select+i.
REQ-023 The counters SHALL be: elem_cnt 0..kernel_elem-1; bank_cnt 0..ROM_NUM-1; base_addr, which advances by kernel_elem when bank_cnt wraps; and kern_cnt 0..KERNEL_NUM-1.
REQ-024 On acceptance with elem_cnt==kernel_elem-1: elem_cnt SHALL clear; bank_cnt SHALL increment, or wrap to 0 with base_addr += kernel_elem; kern_cnt SHALL increment.
REQ-025 The acceptance in REQ-024 with kern_cnt==KERNEL_NUM-1 SHALL be the final word, and the FSM SHALL move to DONE.
REQ-026 Write latency SHALL be 1 cycle: wr_en, wr_addr and wr_data are registered and present in the cycle after acceptance; wr_en is one-hot on bank_cnt.
REQ-027 wr_en SHALL be all-zero in any cycle following a non-accepting cycle; wr_addr and wr_data SHALL hold their last values.
REQ-028 Address arithmetic SHALL be ABS_ADDR_DW bits wide and SHALL wrap modulo 2^ABS_ADDR_DW; overflow is not flagged.
REQ-029 DONE SHALL last exactly 1 cycle, with done=1, then return to IDLE.
REQ-030 The final write strobe and the done pulse SHALL occur in the same cycle.
REQ-031 start SHALL be ignored in LOAD and DONE.
REQ-032 A start arriving in the same cycle that DONE returns to IDLE SHALL NOT be honoured; start is honoured from the following cycle.
REQ-033 in_valid while in_ready==0 SHALL be ignored, and no word is consumed.
REQ-034 Captured KERNEL_NUM and kernel_elem SHALL remain constant during LOAD regardless of their port values.

Reset
REQ-035 While rst_n==0, asynchronously: state=IDLE; all counters 0; wr_en=0; wr_addr=0; wr_data=0; busy=0; done=0; in_ready=0.
REQ-036 Reset asserted mid-load SHALL abort the load immediately with no further writes; a new start is required after release.
REQ-037 Reset SHALL not clear bank contents.

Verification
REQ-038 ROM_NUM=4, KERNEL_NUM=6, kernel_elem=25, continuous valid data 0..149 -> 150 writes.
- Kernel 4, element 0 (word 100) goes to bank 0, addr 25.
- Word 149 goes to bank 1, addr 49 with wr_en=4'b0010.
- done pulses in the cycle of that last write.
REQ-039 KERNEL_NUM=3, kernel_elem=2, in_valid toggling 1,0,1,0 -> writes only on accepted words.
- Addresses in order: b0:0, b0:1, b1:0, b1:1, b2:0, b2:1.
- wr_en=0 in each gap cycle.
REQ-040 start with KERNEL_NUM=0 -> no wr_en ever.
- done=1 exactly 1 cycle after start; busy=1 for that one cycle.
REQ-041 rst_n pulsed low after 10 of 20 words -> wr_en=0 and state=IDLE immediately.
- Further in_valid is ignored (in_ready=0) until a new start.
REQ-042 start re-pulsed during LOAD with different KERNEL_NUM -> ignored; the original write count and layout are unchanged.
